// File: rtl/dmem_controller_pkg.sv
// Shared FSM state encoding and default access latency for the data-memory controller.
package dmem_controller_pkg;

  typedef enum logic [1:0] {
    DMEM_IDLE   = 2'd0,
    DMEM_ACCESS = 2'd1,
    DMEM_DONE   = 2'd2
  } dmem_state_e;

  localparam int DMEM_DEFAULT_LATENCY = 2;

endpackage

// File: rtl/dmem_lane_merge.sv
// Combinational byte-lane helper: zero-extended byte extract, byte insert into the
// old word, or full-word pass-through. Lane 0 is bits 7:0 (little-endian).
module dmem_lane_merge (
  input  logic        is_byte,
  input  logic [1:0]  lane,
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [31:0] new_word
);

  logic [4:0] lane_lsb;

  assign lane_lsb = {lane, 3'b000};

  always_comb begin
    rdata    = old_word;
    new_word = wdata;
    if (is_byte) begin
      rdata                  = {24'd0, old_word[lane_lsb +: 8]};
      new_word               = old_word;
      new_word[lane_lsb +: 8] = wdata[7:0];
    end
  end

endmodule

// File: rtl/dmem_controller.sv
// Multi-cycle data-memory responder with IDLE/ACCESS/DONE handshake and word storage.
// Optional macro DMEM_CTRL_ALIGN_CHECK_EN flags and suppresses misaligned word accesses.
module dmem_controller
  import dmem_controller_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int ADDR_W  = 8,
  parameter int LATENCY = DMEM_DEFAULT_LATENCY
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_read,
  input  logic        req_write,
  input  logic        req_byte,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  dmem_state_e         state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                write_q, write_d;
  logic                byte_q, byte_d;
  logic [ADDR_W+1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [31:0]         rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;

  logic [31:0]         mem_array [DEPTH] = '{default: 32'd0};
  logic [ADDR_W-1:0]   word_idx;
  logic [31:0]         cur_word;
  logic [31:0]         lane_rdata;
  logic [31:0]         lane_word;
  logic                mem_we;
  logic                misaligned;
  logic                req_any;
  logic                unused_addr_hi;

  assign req_any        = req_read | req_write;
  assign word_idx       = addr_q[ADDR_W+1:2];
  assign cur_word       = mem_array[word_idx];
  assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

`ifdef DMEM_CTRL_ALIGN_CHECK_EN
  assign misaligned = ~byte_q & (addr_q[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  dmem_lane_merge u_lane_merge (
    .is_byte  (byte_q),
    .lane     (addr_q[1:0]),
    .old_word (cur_word),
    .wdata    (wdata_q),
    .rdata    (lane_rdata),
    .new_word (lane_word)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    write_d     = write_q;
    byte_d      = byte_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = 1'b0;
    mem_we      = 1'b0;
    case (state_q)
      DMEM_IDLE: begin
        if (req_any) begin
          write_d = req_write;
          byte_d  = req_byte;
          addr_d  = req_addr[ADDR_W+1:0];
          wdata_d = req_wdata;
          cnt_d   = CNT_LOAD;
          state_d = DMEM_ACCESS;
        end
      end
      DMEM_ACCESS: begin
        if (cnt_q == '0) begin
          // The array is touched only on the final ACCESS cycle so an abort never corrupts it.
          mem_we      = write_q & ~misaligned;
          rsp_rdata_d = (write_q | misaligned) ? 32'd0 : lane_rdata;
          rsp_err_d   = misaligned;
          rsp_valid_d = 1'b1;
          state_d     = DMEM_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DMEM_DONE: begin
        state_d = DMEM_IDLE;
      end
      default: begin
        state_d = DMEM_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= DMEM_IDLE;
      cnt_q       <= '0;
      write_q     <= 1'b0;
      byte_q      <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      write_q     <= write_d;
      byte_q      <= byte_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem_array[word_idx] <= lane_word;
    end
  end

  assign stall     = reset & (((state_q == DMEM_IDLE) & req_any) | (state_q == DMEM_ACCESS));
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_controller.sv
// Randomized and directed bench for dmem_controller against a word-array reference model.
module tb_dmem_controller;

  localparam int LAT   = 2;
  localparam int DEPTH = 256;

  logic        clock, reset;
  logic        req_read, req_write, req_byte;
  logic [31:0] req_addr, req_wdata;
  logic        stall, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;

  int errors = 0;
  int checks = 0;
  logic [31:0] model_mem [DEPTH];

  dmem_controller dut (
    .clock     (clock),
    .reset     (reset),
    .req_read  (req_read),
    .req_write (req_write),
    .req_byte  (req_byte),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .stall     (stall),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Reference: memory as plain array, addresses decoded by division/modulo.
  function automatic void model_access(input bit wr, input bit byt, input logic [31:0] addr,
                                       input logic [31:0] wdata, output logic [31:0] rdata,
                                       output logic err);
    int unsigned idx;
    int unsigned shift;
    bit mis;
    idx   = (addr / 4) % DEPTH;
    shift = (addr % 4) * 8;
`ifdef DMEM_CTRL_ALIGN_CHECK_EN
    mis = !byt && (addr % 4 != 0);
`else
    mis = 1'b0;
`endif
    err   = mis;
    rdata = 32'd0;
    if (mis) return;
    if (wr) begin
      if (byt) model_mem[idx] = (model_mem[idx] & ~(32'hFF << shift)) | ((wdata & 32'hFF) << shift);
      else     model_mem[idx] = wdata;
    end else begin
      rdata = byt ? ((model_mem[idx] >> shift) & 32'hFF) : model_mem[idx];
    end
  endfunction

  // Drives one command from a negedge in IDLE; returns observations, ends at the negedge after DONE.
  task automatic run_access(input bit rd, input bit wr, input bit byt, input logic [31:0] addr,
                            input logic [31:0] wdata, output int stall_cycles, output int valid_cycle,
                            output logic [31:0] rdata, output logic err, output bit pulse_ok);
    stall_cycles = 0;
    valid_cycle  = -1;
    rdata        = 32'd0;
    err          = 1'b0;
    pulse_ok     = 1'b0;
    req_read = rd; req_write = wr; req_byte = byt; req_addr = addr; req_wdata = wdata;
    #1;
    for (int c = 0; c < 20; c++) begin
      if (c > 0) begin
        @(posedge clock); #1;
        req_read = 1'b0; req_write = 1'b0;
        req_byte = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
        @(negedge clock);
      end
      if (stall) stall_cycles++;
      if (rsp_valid) begin
        valid_cycle = c;
        rdata       = rsp_rdata;
        err         = rsp_err;
        break;
      end
    end
    if (valid_cycle >= 0) begin
      @(negedge clock);
      pulse_ok = !rsp_valid && (rsp_rdata === rdata);
    end
  endtask

  task automatic test_reset();
    req_read = 1'b1; req_write = 1'b0; req_byte = 1'b0; req_addr = 32'h10; req_wdata = 32'h0;
    repeat (3) @(negedge clock);
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", stall); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", rsp_valid); end
    checks++; if (rsp_rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", rsp_rdata); end
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", rsp_err); end
    req_read = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_word_write_read();
    int sc, vc; logic [31:0] rd, mr; logic er, me; bit po;
    run_access(0, 1, 0, 32'h10, 32'hDEADBEEF, sc, vc, rd, er, po);
    model_access(1, 0, 32'h10, 32'hDEADBEEF, mr, me);
    checks++; if (sc != LAT + 1) begin errors++; $display("FAIL wr_stall_cycles: got %0d expected %0d", sc, LAT + 1); end
    checks++; if (vc != LAT + 1) begin errors++; $display("FAIL wr_valid_cycle: got %0d expected %0d", vc, LAT + 1); end
    checks++; if (rd !== 32'd0) begin errors++; $display("FAIL wr_rdata: got %h expected 0", rd); end
    checks++; if (!po) begin errors++; $display("FAIL wr_pulse: got not-single-pulse expected single-pulse"); end
    run_access(1, 0, 0, 32'h10, 32'h0, sc, vc, rd, er, po);
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_word: got %h expected deadbeef", rd); end
    checks++; if (vc != LAT + 1) begin errors++; $display("FAIL rd_valid_cycle: got %0d expected %0d", vc, LAT + 1); end
  endtask

  task automatic test_byte();
    int sc, vc; logic [31:0] rd, mr; logic er, me; bit po;
    run_access(0, 1, 1, 32'h12, 32'h000000AA, sc, vc, rd, er, po);
    model_access(1, 1, 32'h12, 32'h000000AA, mr, me);
    run_access(1, 0, 0, 32'h10, 32'h0, sc, vc, rd, er, po);
    checks++; if (rd !== 32'hDEAABEEF) begin errors++; $display("FAIL byte_write: got %h expected deaabeef", rd); end
    run_access(1, 0, 1, 32'h13, 32'h0, sc, vc, rd, er, po);
    checks++; if (rd !== 32'h000000DE) begin errors++; $display("FAIL byte_read: got %h expected 000000de", rd); end
  endtask

  task automatic test_wrap();
    int sc, vc; logic [31:0] rd, mr; logic er, me; bit po;
    run_access(0, 1, 0, 32'h400, 32'h12345678, sc, vc, rd, er, po);
    model_access(1, 0, 32'h400, 32'h12345678, mr, me);
    run_access(1, 0, 0, 32'h0, 32'h0, sc, vc, rd, er, po);
    checks++; if (rd !== 32'h12345678) begin errors++; $display("FAIL wrap: got %h expected 12345678", rd); end
  endtask

  task automatic test_both_req();
    int sc, vc; logic [31:0] rd, mr; logic er, me; bit po;
    run_access(1, 1, 0, 32'h30, 32'hA5A5_0F0F, sc, vc, rd, er, po);
    model_access(1, 0, 32'h30, 32'hA5A5_0F0F, mr, me);
    checks++; if (rd !== 32'd0) begin errors++; $display("FAIL both_req_rdata: got %h expected 0", rd); end
    run_access(1, 0, 0, 32'h30, 32'h0, sc, vc, rd, er, po);
    checks++; if (rd !== 32'hA5A5_0F0F) begin errors++; $display("FAIL both_req_write: got %h expected a5a50f0f", rd); end
  endtask

  task automatic test_reset_mid();
    int sc, vc; logic [31:0] rd, mr; logic er, me; bit po; bit seen;
    run_access(0, 1, 0, 32'h20, 32'h1111_2222, sc, vc, rd, er, po);
    model_access(1, 0, 32'h20, 32'h1111_2222, mr, me);
    req_write = 1'b1; req_read = 1'b0; req_byte = 1'b0; req_addr = 32'h20; req_wdata = 32'hCAFEF00D;
    @(posedge clock); #1;
    req_write = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL midrst_stall: got %b expected 0", stall); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b expected 0", rsp_valid); end
    @(posedge clock); #1;
    reset = 1'b1;
    seen = 1'b0;
    repeat (5) begin
      @(negedge clock);
      if (rsp_valid || stall) seen = 1'b1;
    end
    checks++; if (seen) begin errors++; $display("FAIL midrst_idle: got activity expected idle"); end
    run_access(1, 0, 0, 32'h20, 32'h0, sc, vc, rd, er, po);
    model_access(0, 0, 32'h20, 32'h0, mr, me);
    checks++; if (rd !== mr) begin errors++; $display("FAIL midrst_discard: got %h expected %h", rd, mr); end
    checks++; if (vc != LAT + 1) begin errors++; $display("FAIL midrst_timing: got %0d expected %0d", vc, LAT + 1); end
  endtask

  task automatic test_misaligned();
    int sc, vc; logic [31:0] rd, mr, exp_word; logic er, me, exp_err; bit po;
`ifdef DMEM_CTRL_ALIGN_CHECK_EN
    exp_err  = 1'b1;
    exp_word = model_mem[8];
`else
    exp_err  = 1'b0;
    exp_word = 32'h55AA_33CC;
`endif
    run_access(0, 1, 0, 32'h21, 32'h55AA_33CC, sc, vc, rd, er, po);
    model_access(1, 0, 32'h21, 32'h55AA_33CC, mr, me);
    checks++; if (er !== exp_err) begin errors++; $display("FAIL misalign_err: got %b expected %b", er, exp_err); end
    checks++; if (vc != LAT + 1) begin errors++; $display("FAIL misalign_timing: got %0d expected %0d", vc, LAT + 1); end
    run_access(1, 0, 0, 32'h20, 32'h0, sc, vc, rd, er, po);
    checks++; if (rd !== exp_word) begin errors++; $display("FAIL misalign_word: got %h expected %h", rd, exp_word); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL aligned_err: got %b expected 0", er); end
  endtask

  task automatic test_random();
    int sc, vc; logic [31:0] rd, mr, addr, wd; logic er, me; bit po, rdb, wrb, byt;
    for (int i = 0; i < 40; i++) begin
      wrb  = 1'($urandom);
      rdb  = !wrb || 1'($urandom);
      byt  = 1'($urandom);
      addr = ($urandom & 32'hFFFF_FC00) | $urandom_range(0, 63);
      wd   = $urandom;
      run_access(rdb, wrb, byt, addr, wd, sc, vc, rd, er, po);
      model_access(wrb, byt, addr, wd, mr, me);
      checks++;
      if (rd !== mr || er !== me || vc != LAT + 1 || !po) begin
        errors++;
        $display("FAIL random[%0d]: got rdata=%h err=%b cyc=%0d expected rdata=%h err=%b cyc=%0d",
                 i, rd, er, vc, mr, me, LAT + 1);
      end
    end
  endtask

  task automatic test_back_to_back();
    int v0, v1; logic [31:0] mr; logic me; bit stall_in_done;
    v0 = -1; v1 = -1; stall_in_done = 1'b0;
    model_access(0, 0, 32'h10, 32'h0, mr, me);
    req_read = 1'b1; req_write = 1'b0; req_byte = 1'b0; req_addr = 32'h10; req_wdata = 32'h0;
    #1;
    for (int c = 0; c < 20; c++) begin
      if (c > 0) @(negedge clock);
      if (rsp_valid) begin
        if (stall) stall_in_done = 1'b1;
        checks++; if (rsp_rdata !== mr) begin errors++; $display("FAIL b2b_rdata: got %h expected %h", rsp_rdata, mr); end
        if (v0 < 0) v0 = c;
        else begin
          v1 = c;
          break;
        end
      end
    end
    req_read = 1'b0;
    checks++; if (v1 - v0 != LAT + 2) begin errors++; $display("FAIL b2b_spacing: got %0d expected %0d", v1 - v0, LAT + 2); end
    checks++; if (stall_in_done) begin errors++; $display("FAIL b2b_done_stall: got 1 expected 0"); end
    @(negedge clock);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'd0;
    reset = 1'b1; req_read = 1'b0; req_write = 1'b0; req_byte = 1'b0;
    req_addr = 32'd0; req_wdata = 32'd0;
    #3 reset = 1'b0;
    test_reset();
    test_word_write_read();
    test_byte();
    test_wrap();
    test_both_req();
    test_reset_mid();
    test_misaligned();
    test_random();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
